// File: rtl/johnson_slot_arbiter.sv
// rtl/johnson_slot_arbiter.sv - Johnson-ring time-slot arbiter, round-robin grant per owned slot
// Optional JSA_SELF_CORRECT_EN: illegal ring codes are forced back to 0000 and flagged on err.
module johnson_slot_arbiter #(
  parameter  int N_REQ    = 4,
  parameter  int RING_W   = 4,
  parameter  int MAX_HOLD = 8,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int SLOT_W   = $clog2(2*RING_W),
  localparam int HOLD_W   = $clog2(MAX_HOLD+1)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [N_REQ-1:0]  req,
  input  logic              cfg_ld,
  input  logic [RING_W-1:0] cfg_din,
  output logic [N_REQ-1:0]  gnt,
  output logic [ID_W-1:0]   gnt_id,
  output logic              busy,
  output logic [SLOT_W-1:0] slot,
  output logic [RING_W-1:0] ring_q,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, SCAN, GRANT} state_e;

  state_e            state_q, state_d;
  logic [RING_W-1:0] ring_d, ring_step;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [SLOT_W:0]   pop;
  logic [ID_W-1:0]   owner;
  logic              illegal;

  function automatic logic [SLOT_W:0] popcnt(input logic [RING_W-1:0] v);
    popcnt = '0;
    for (int i = 0; i < RING_W; i++) popcnt = popcnt + (SLOT_W+1)'(v[i]);
  endfunction

  assign ring_step = {ring_q[RING_W-2:0], ~ring_q[RING_W-1]};
  assign pop       = popcnt(ring_q);

  // Rising half of the period counts ones, falling half counts down from 2*RING_W.
  always_comb begin
    slot = '0;
    if (ring_q[0] || ring_q == '0) slot = SLOT_W'(pop);
    else                           slot = SLOT_W'((SLOT_W+1)'(2*RING_W) - pop);
  end

  assign owner  = ID_W'(int'(slot) % N_REQ);
  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = (state_q != IDLE);

`ifdef JSA_SELF_CORRECT_EN
  logic err_q;

  // Legal Johnson codes have at most one transition between adjacent bits.
  assign illegal = popcnt({1'b0, ring_q[RING_W-2:0] ^ ring_q[RING_W-1:1]}) > (SLOT_W+1)'(1);
  assign err     = err_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) err_q <= 1'b0;
    else      err_q <= illegal;
  end
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ring_d   = ring_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    hold_d   = hold_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_ld)            ring_d  = cfg_din;
        else if (en && |req)   state_d = SCAN;
      end
      SCAN: begin
        if (!en || req == '0) begin
          state_d = IDLE;
        end else if (req[owner] && !illegal) begin
          state_d  = GRANT;
          gnt_d    = N_REQ'(1) << owner;
          gnt_id_d = owner;
          hold_d   = HOLD_W'(1);
        end else begin
          ring_d = ring_step;
        end
      end
      GRANT: begin
        if (!req[gnt_id_q] || hold_q == HOLD_W'(MAX_HOLD)) begin
          gnt_d    = '0;
          gnt_id_d = '0;
          hold_d   = '0;
          ring_d   = ring_step;
          state_d  = (en && |req) ? SCAN : IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh seed load takes precedence over repairing the previous code.
    if (illegal && state_q != GRANT && !(state_q == IDLE && cfg_ld)) ring_d = '0;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      ring_q   <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      ring_q   <= ring_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: tb/tb_johnson_slot_arbiter.sv
// tb/tb_johnson_slot_arbiter.sv - self-checking bench for johnson_slot_arbiter
module tb_johnson_slot_arbiter;
  localparam int N = 4, W = 4, MAXH = 8, P = 2*W;

  logic         clk = 1'b0;
  logic         clr, en, cfg_ld;
  logic [N-1:0] req;
  logic [W-1:0] cfg_din;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy, err;
  logic [2:0]   slot;
  logic [W-1:0] ring_q;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  johnson_slot_arbiter #(.N_REQ(N), .RING_W(W), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .clr(clr), .en(en), .req(req), .cfg_ld(cfg_ld), .cfg_din(cfg_din),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .slot(slot), .ring_q(ring_q), .err(err)
  );

  // Reference model: ring tracked as a position in the 2*W slot table.
  int           m_state, m_gid, m_hold, n_state, n_gid, n_hold;
  logic         m_on, m_err, n_on, n_err;
  logic [W-1:0] m_raw, n_raw;
  int           t_ids[$], t_lens[$], t_gaps[$], t_slots[$];
  int           t_gap;
  logic         t_prev;

  typedef struct {
    logic en; logic [3:0] req; logic cfg_ld; logic [3:0] cfg_din;
    logic [3:0] e_gnt; logic [1:0] e_id; logic e_busy; logic [3:0] e_ring; logic [2:0] e_slot;
  } vec_t;
  vec_t tbl[19];

  function automatic logic [W-1:0] code_of(input int k);
    logic [W-1:0] all1;
    all1 = '1;
    if (k <= W) return W'((1 << k) - 1);
    return all1 & ~W'((1 << (k - W)) - 1);
  endfunction

  function automatic int pos_of(input logic [W-1:0] r);
    for (int k = 0; k < P; k++) if (code_of(k) == r) return k;
    return -1;
  endfunction

  function automatic logic [W-1:0] next_raw(input logic [W-1:0] r);
    if (pos_of(r) >= 0) return code_of((pos_of(r) + 1) % P);
    return {r[W-2:0], ~r[W-1]};
  endfunction

  function automatic int slot_of(input logic [W-1:0] r);
    if (pos_of(r) >= 0) return pos_of(r);
    if (r[0]) return $countones(r);
    return P - $countones(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_raw = '0; m_on = 1'b0; m_gid = 0; m_hold = 0; m_err = 1'b0;
  endtask

  task automatic model_next();
    int  own;
    logic ill;
    own = slot_of(m_raw) % N;
    ill = 1'b0;
`ifdef JSA_SELF_CORRECT_EN
    ill = (pos_of(m_raw) < 0);
`endif
    n_state = m_state; n_raw = m_raw; n_on = m_on; n_gid = m_gid; n_hold = m_hold; n_err = ill;
    case (m_state)
      0: if (cfg_ld) n_raw = cfg_din; else if (en && req != 0) n_state = 1;
      1: begin
        if (!en || req == 0) n_state = 0;
        else if (req[own] && !ill) begin n_state = 2; n_on = 1'b1; n_gid = own; n_hold = 1; end
        else n_raw = next_raw(m_raw);
      end
      default: begin
        if (!req[m_gid] || m_hold == MAXH) begin
          n_on = 1'b0; n_gid = 0; n_hold = 0; n_raw = next_raw(m_raw);
          n_state = (en && req != 0) ? 1 : 0;
        end else n_hold = m_hold + 1;
      end
    endcase
    if (ill && m_state != 2 && !(m_state == 0 && cfg_ld)) n_raw = '0;
  endtask

  task automatic compare_all();
    check("gnt", 32'(gnt), m_on ? 32'(1 << m_gid) : 32'(0));
    check("gnt_id", 32'(gnt_id), 32'(m_gid));
    check("busy", 32'(busy), 32'(m_state != 0));
    check("slot", 32'(slot), 32'(slot_of(m_raw)));
    check("ring_q", 32'(ring_q), 32'(m_raw));
    check("err", 32'(err), 32'(m_err));
    check("gnt_onehot0", 32'($onehot0(gnt)), 32'(1));
  endtask

  task automatic track_clear();
    t_ids.delete(); t_lens.delete(); t_gaps.delete(); t_slots.delete();
    t_gap = 0; t_prev = 1'b0;
  endtask

  task automatic step();
    model_next();
    @(posedge clk); #1;
    m_state = n_state; m_raw = n_raw; m_on = n_on; m_gid = n_gid; m_hold = n_hold; m_err = n_err;
    compare_all();
    if (gnt != 0) begin
      if (!t_prev) begin
        t_ids.push_back(int'(gnt_id)); t_lens.push_back(1); t_gaps.push_back(t_gap);
        t_slots.push_back(int'(slot)); t_gap = 0;
      end else t_lens[t_lens.size()-1] = t_lens[t_lens.size()-1] + 1;
      t_prev = 1'b1;
    end else begin
      t_gap++; t_prev = 1'b0;
    end
  endtask

  task automatic do_reset();
    en = 1'b0; req = '0; cfg_ld = 1'b0; cfg_din = '0; clr = 1'b0;
    model_reset();
    @(posedge clk); #1;
    compare_all();
    @(negedge clk); clr = 1'b1;
    track_clear();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'b0100, 1'b0, 4'h0, 4'b0000, 2'd0, 1'b1, 4'b0000, 3'd0};
    tbl[1]  = '{1'b1, 4'b0100, 1'b0, 4'h0, 4'b0000, 2'd0, 1'b1, 4'b0001, 3'd1};
    tbl[2]  = '{1'b1, 4'b0100, 1'b0, 4'h0, 4'b0000, 2'd0, 1'b1, 4'b0011, 3'd2};
    tbl[3]  = '{1'b1, 4'b0100, 1'b0, 4'h0, 4'b0100, 2'd2, 1'b1, 4'b0011, 3'd2};
    tbl[4]  = '{1'b1, 4'b0100, 1'b0, 4'h0, 4'b0100, 2'd2, 1'b1, 4'b0011, 3'd2};
    tbl[5]  = '{1'b1, 4'b0000, 1'b0, 4'h0, 4'b0000, 2'd0, 1'b0, 4'b0111, 3'd3};
    tbl[6]  = '{1'b1, 4'b0000, 1'b0, 4'h0, 4'b0000, 2'd0, 1'b0, 4'b0111, 3'd3};
    tbl[7]  = '{1'b1, 4'b0010, 1'b1, 4'hE, 4'b0000, 2'd0, 1'b0, 4'b1110, 3'd5};
    tbl[8]  = '{1'b1, 4'b0010, 1'b0, 4'h0, 4'b0000, 2'd0, 1'b1, 4'b1110, 3'd5};
    tbl[9]  = '{1'b1, 4'b0010, 1'b0, 4'h0, 4'b0010, 2'd1, 1'b1, 4'b1110, 3'd5};
    tbl[10] = '{1'b1, 4'b0010, 1'b1, 4'h0, 4'b0010, 2'd1, 1'b1, 4'b1110, 3'd5};
    tbl[11] = '{1'b1, 4'b0000, 1'b0, 4'h0, 4'b0000, 2'd0, 1'b0, 4'b1100, 3'd6};
    tbl[12] = '{1'b0, 4'b0001, 1'b0, 4'h0, 4'b0000, 2'd0, 1'b0, 4'b1100, 3'd6};
    tbl[13] = '{1'b1, 4'b0001, 1'b0, 4'h0, 4'b0000, 2'd0, 1'b1, 4'b1100, 3'd6};
    tbl[14] = '{1'b1, 4'b0001, 1'b0, 4'h0, 4'b0000, 2'd0, 1'b1, 4'b1000, 3'd7};
    tbl[15] = '{1'b1, 4'b0001, 1'b0, 4'h0, 4'b0000, 2'd0, 1'b1, 4'b0000, 3'd0};
    tbl[16] = '{1'b1, 4'b0001, 1'b0, 4'h0, 4'b0001, 2'd0, 1'b1, 4'b0000, 3'd0};
    tbl[17] = '{1'b0, 4'b0001, 1'b0, 4'h0, 4'b0001, 2'd0, 1'b1, 4'b0000, 3'd0};
    tbl[18] = '{1'b0, 4'b0000, 1'b0, 4'h0, 4'b0000, 2'd0, 1'b0, 4'b0001, 3'd1};

    // Directed table: single requester, seed load, cfg_ld in GRANT, en drop in GRANT
    do_reset();
    for (int i = 0; i < 19; i++) begin
      en = tbl[i].en; req = tbl[i].req; cfg_ld = tbl[i].cfg_ld; cfg_din = tbl[i].cfg_din;
      step();
      check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].e_gnt));
      check($sformatf("tbl%0d_id", i), 32'(gnt_id), 32'(tbl[i].e_id));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("tbl%0d_ring", i), 32'(ring_q), 32'(tbl[i].e_ring));
      check($sformatf("tbl%0d_slot", i), 32'(slot), 32'(tbl[i].e_slot));
    end

    // Asynchronous reset in the middle of a grant
    do_reset();
    en = 1'b1; req = 4'b0001;
    for (int i = 0; i < 4; i++) step();
    check("pre_reset_gnt", 32'(gnt), 32'(4'b0001));
    #2 clr = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'(0));
    check("async_gnt_id", 32'(gnt_id), 32'(0));
    check("async_busy", 32'(busy), 32'(0));
    check("async_ring", 32'(ring_q), 32'(0));
    check("async_slot", 32'(slot), 32'(0));
    check("async_err", 32'(err), 32'(0));
    @(negedge clk); clr = 1'b1; en = 1'b0;
    model_reset(); track_clear();
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_reset_busy", 32'(busy), 32'(0));
    end

    // Round robin with all requesters held
    do_reset();
    en = 1'b1; req = 4'b1111;
    for (int i = 0; i < 80; i++) step();
    check("rr_tenures", 32'(t_ids.size() >= 8), 32'(1));
    for (int k = 0; k < 8 && k < t_ids.size(); k++) begin
      check($sformatf("rr_id%0d", k), 32'(t_ids[k]), 32'(k % N));
      check($sformatf("rr_len%0d", k), 32'(t_lens[k]), 32'(MAXH));
      if (k > 0) check($sformatf("rr_gap%0d", k), 32'(t_gaps[k]), 32'(1));
    end

    // Hold limit with a single requester
    do_reset();
    en = 1'b1; req = 4'b0001;
    for (int i = 0; i < 25; i++) step();
    check("hold_tenures", 32'(t_ids.size() >= 2), 32'(1));
    if (t_ids.size() >= 2) begin
      check("hold_len", 32'(t_lens[0]), 32'(MAXH));
      check("hold_regrant_slot", 32'(t_slots[1]), 32'(4));
      check("hold_regrant_id", 32'(t_ids[1]), 32'(0));
      check("hold_gap", 32'(t_gaps[1]), 32'(4));
    end

    // Request dropped on the same cycle the hold limit expires
    do_reset();
    en = 1'b1; req = 4'b0001;
    step(); step();
    for (int i = 0; i < 7; i++) step();
    check("expiry_still_gnt", 32'(gnt), 32'(4'b0001));
    req = 4'b0000;
    step();
    check("expiry_gnt", 32'(gnt), 32'(0));
    check("expiry_ring", 32'(ring_q), 32'(4'b0001));
    step();
    check("expiry_single_step", 32'(ring_q), 32'(4'b0001));

    // Illegal seed
    do_reset();
    cfg_ld = 1'b1; cfg_din = 4'b0101;
    step();
    check("illegal_loaded", 32'(ring_q), 32'(4'b0101));
    cfg_ld = 1'b0; en = 1'b1; req = 4'b0001;
`ifdef JSA_SELF_CORRECT_EN
    step();
    check("fix_err", 32'(err), 32'(1));
    check("fix_ring", 32'(ring_q), 32'(0));
    step();
    check("fix_err_pulse", 32'(err), 32'(0));
    check("fix_grant", 32'(gnt), 32'(4'b0001));
`else
    for (int i = 0; i < 17; i++) begin
      step();
      if (i == 8) check("orbit_period", 32'(ring_q), 32'(4'b0101));
    end
    check("orbit_no_grant", 32'(t_ids.size()), 32'(0));
`endif
    req = 4'b0000;
    step();

    // Randomised run against the model
    do_reset();
    req = '0;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      cfg_ld  = ($urandom_range(0, 15) == 0);
      cfg_din = code_of(int'($urandom_range(0, P-1)));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
